// File: rtl/nice_pkg.sv
// Shared types for the weight SRAM arbiter: FSM states, requester owner encoding
// and the read-return tag carried alongside each outstanding SRAM read.
package nice_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CONV = 1'b0,
    OWN_FC   = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   last;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_CONV, last: 1'b0};

endpackage

// File: rtl/wsram_rd_tag_pipe.sv
// DEPTH-stage shift register that delays each read tag by the SRAM read latency,
// so the tag lines up with the word coming back on sram_rdata.
module wsram_rd_tag_pipe
  import nice_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/weight_sram_arbiter.sv
// Burst-read arbiter sharing one single-port weight SRAM between the conv and FC
// weight consumers. Define WSRAM_ARB_RR_EN for round-robin; default is conv-first.
//
// state | meaning
// IDLE  | no burst active; grant the winning requester when any req is high
// BURST | issue one read per cycle at base + cnt until cnt == len
module weight_sram_arbiter
  import nice_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int LW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          conv_req,
  input  logic [AW-1:0] conv_base,
  input  logic [LW-1:0] conv_len,
  output logic          conv_ack,
  output logic [DW-1:0] conv_rdata,
  output logic          conv_rvalid,
  output logic          conv_rlast,
  input  logic          fc_req,
  input  logic [AW-1:0] fc_base,
  input  logic [LW-1:0] fc_len,
  output logic          fc_ack,
  output logic [DW-1:0] fc_rdata,
  output logic          fc_rvalid,
  output logic          fc_rlast,
  output logic          sram_ce,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  owner_t        owner_q, owner_d;
  logic          ce_q, ce_d;
  logic          conv_ack_q, conv_ack_d;
  logic          fc_ack_q, fc_ack_d;
  owner_t        win;
  logic          any_req;
  tag_t          tag_in, tag_out;

  assign any_req = conv_req | fc_req;

`ifdef WSRAM_ARB_RR_EN
  owner_t last_q;

  // On contention the owner not granted last time wins; a lone requester always wins.
  always_comb begin
    if (conv_req && fc_req) win = (last_q == OWN_CONV) ? OWN_FC : OWN_CONV;
    else                    win = conv_req ? OWN_CONV : OWN_FC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          last_q <= OWN_FC;
    else if (state_q == IDLE && any_req) last_q <= win;
  end
`else
  assign win = conv_req ? OWN_CONV : OWN_FC;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    ce_d       = 1'b0;
    conv_ack_d = 1'b0;
    fc_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = BURST;
          owner_d    = win;
          cnt_d      = '0;
          ce_d       = 1'b1;
          base_d     = (win == OWN_FC) ? fc_base : conv_base;
          len_d      = (win == OWN_FC) ? fc_len  : conv_len;
          addr_d     = base_d;
          conv_ack_d = (win == OWN_CONV);
          fc_ack_d   = (win == OWN_FC);
        end
      end
      BURST: begin
        if (cnt_q == len_q) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q + LW'(1);
          ce_d   = 1'b1;
          addr_d = base_q + AW'(cnt_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      owner_q    <= OWN_CONV;
      ce_q       <= 1'b0;
      conv_ack_q <= 1'b0;
      fc_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      owner_q    <= owner_d;
      ce_q       <= ce_d;
      conv_ack_q <= conv_ack_d;
      fc_ack_q   <= fc_ack_d;
    end
  end

  // Tag describes the read being issued this cycle; it emerges when its data returns.
  assign tag_in = '{valid: ce_q, owner: owner_q, last: (cnt_q == len_q)};

  wsram_rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign conv_rvalid = tag_out.valid && (tag_out.owner == OWN_CONV);
  assign fc_rvalid   = tag_out.valid && (tag_out.owner == OWN_FC);
  assign conv_rlast  = conv_rvalid && tag_out.last;
  assign fc_rlast    = fc_rvalid && tag_out.last;
  assign conv_rdata  = sram_rdata;
  assign fc_rdata    = sram_rdata;
  assign conv_ack    = conv_ack_q;
  assign fc_ack      = fc_ack_q;
  assign sram_ce     = ce_q;
  assign sram_addr   = addr_q;
  assign busy        = (state_q == BURST);

endmodule

// File: tb/tb_weight_sram_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) share stimulus; expected
// timing and data come from burst arithmetic, returned words are checked by monitors.
module tb_weight_sram_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LW = 8;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   last_fc = 1'b1;

  logic          conv_req = 1'b0, fc_req = 1'b0;
  logic [AW-1:0] conv_base = '0, fc_base = '0;
  logic [LW-1:0] conv_len = '0, fc_len = '0;

  logic          conv_ack [2], fc_ack [2], conv_rvalid [2], fc_rvalid [2];
  logic          conv_rlast [2], fc_rlast [2], sram_ce [2], busy [2];
  logic [DW-1:0] conv_rdata [2], fc_rdata [2], sram_rdata [2];
  logic [AW-1:0] sram_addr [2];

  exp_t exp_q [2][2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic mon_check(input int i, input int o, input logic v, input logic l,
                           input logic [15:0] d);
    exp_t e;
    chk($sformatf("i%0d_o%0d_rlast_gated", i, o), int'(l & ~v), 0);
    if (v) begin
      if (exp_q[i][o].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL i%0d_o%0d_unexpected_rvalid @cyc %0d: got rvalid=1 expected 0", i, o, cyc);
      end else begin
        e = exp_q[i][o].pop_front();
        chk($sformatf("i%0d_o%0d_rdata", i, o), d, e.data);
        chk($sformatf("i%0d_o%0d_rlast", i, o), l, e.last);
        chk($sformatf("i%0d_o%0d_rcycle", i, o), cyc, e.cyc);
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RD_LAT_G = (g == 0) ? 1 : 3;
    logic [DW-1:0] mpipe [RD_LAT_G];

    weight_sram_arbiter #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(RD_LAT_G)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .conv_req(conv_req), .conv_base(conv_base), .conv_len(conv_len),
      .conv_ack(conv_ack[g]), .conv_rdata(conv_rdata[g]),
      .conv_rvalid(conv_rvalid[g]), .conv_rlast(conv_rlast[g]),
      .fc_req(fc_req), .fc_base(fc_base), .fc_len(fc_len),
      .fc_ack(fc_ack[g]), .fc_rdata(fc_rdata[g]),
      .fc_rvalid(fc_rvalid[g]), .fc_rlast(fc_rlast[g]),
      .sram_ce(sram_ce[g]), .sram_addr(sram_addr[g]), .sram_rdata(sram_rdata[g]),
      .busy(busy[g])
    );

    always @(posedge clk) begin
      mpipe[0] <= sram_ce[g] ? mem_f(sram_addr[g]) : 16'hDEAD;
      for (int i = 1; i < RD_LAT_G; i++) mpipe[i] <= mpipe[i-1];
    end
    assign sram_rdata[g] = mpipe[RD_LAT_G-1];

    always @(negedge clk) begin
      mon_check(g, 0, conv_rvalid[g], conv_rlast[g], conv_rdata[g]);
      mon_check(g, 1, fc_rvalid[g], fc_rlast[g], fc_rdata[g]);
    end
  end

  task automatic push_burst(input int o, input logic [15:0] b, input int len, input int a);
    exp_t e;
    logic [15:0] addr;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k <= len; k++) begin
        addr   = b + 16'(k);
        e.data = mem_f(addr);
        e.last = (k == len);
        e.cyc  = a + k + lat(i);
        exp_q[i][o].push_back(e);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_conv_ack"}, conv_ack[i], 0);
      chk({tag, "_fc_ack"}, fc_ack[i], 0);
      chk({tag, "_conv_rvalid"}, conv_rvalid[i], 0);
      chk({tag, "_fc_rvalid"}, fc_rvalid[i], 0);
      chk({tag, "_conv_rlast"}, conv_rlast[i], 0);
      chk({tag, "_fc_rlast"}, fc_rlast[i], 0);
      chk({tag, "_sram_ce"}, sram_ce[i], 0);
      chk({tag, "_sram_addr"}, sram_addr[i], 0);
      chk({tag, "_busy"}, busy[i], 0);
    end
  endtask

  // Requests are sampled at the edge ending cycle t; the winner owns t+1..t+1+len,
  // the loser is granted after one idle bubble.
  task automatic run_pair(input bit rc, input logic [15:0] cb, input int cl,
                          input bit rf, input logic [15:0] fb, input int fl);
    int t, a_c, a_f, e_end;
    bit first_fc, in_c, in_f;
    logic [15:0] ea;
    @(negedge clk);
    t = cyc;
    conv_req = rc; conv_base = cb; conv_len = LW'(cl);
    fc_req   = rf; fc_base   = fb; fc_len   = LW'(fl);
    a_c = -100; a_f = -100;
`ifdef WSRAM_ARB_RR_EN
    first_fc = (rc && rf) ? !last_fc : rf;
`else
    first_fc = !rc;
`endif
    if (first_fc) begin
      a_f = t + 1;
      if (rc) a_c = t + 3 + fl;
    end else begin
      a_c = t + 1;
      if (rf) a_f = t + 3 + cl;
    end
    last_fc = (rc && rf) ? !first_fc : rf;
    if (rc) push_burst(0, cb, cl, a_c);
    if (rf) push_burst(1, fb, fl, a_f);
    e_end = 0;
    if (rc && a_c + cl > e_end) e_end = a_c + cl;
    if (rf && a_f + fl > e_end) e_end = a_f + fl;
    while (cyc <= e_end) begin
      @(negedge clk);
      in_c = rc && cyc >= a_c && cyc <= a_c + cl;
      in_f = rf && cyc >= a_f && cyc <= a_f + fl;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d_conv_ack", i), conv_ack[i], int'(rc && cyc == a_c));
        chk($sformatf("i%0d_fc_ack", i), fc_ack[i], int'(rf && cyc == a_f));
        chk($sformatf("i%0d_sram_ce", i), sram_ce[i], int'(in_c || in_f));
        chk($sformatf("i%0d_busy", i), busy[i], int'(in_c || in_f));
        if (in_c || in_f) begin
          ea = in_c ? cb + 16'(cyc - a_c) : fb + 16'(cyc - a_f);
          chk($sformatf("i%0d_sram_addr", i), sram_addr[i], ea);
        end
      end
      if (cyc == a_c) conv_req = 1'b0;
      if (cyc == a_f) fc_req = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit rc, rf;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pair(1, 16'h0010, 3, 0, 16'h0000, 0);
    repeat (3) run_pair(1, 16'h0010, 3, 1, 16'h0100, 1);
    run_pair(1, 16'hFFFE, 2, 0, 16'h0000, 0);
    run_pair(0, 16'h0000, 0, 1, 16'hFFFE, 2);
    run_pair(1, 16'h0042, 0, 0, 16'h0000, 0);
    run_pair(1, 16'h1234, 0, 1, 16'h4321, 0);

    // Reset during word 2 of a len-7 burst: only words already returned are expected.
    @(negedge clk);
    t = cyc;
    conv_req = 1'b1; conv_base = 16'h0200; conv_len = 8'd7;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k + lat(i) <= 1; k++) begin
        exp_t e;
        e.data = mem_f(16'h0200 + 16'(k));
        e.last = 1'b0;
        e.cyc  = t + 1 + k + lat(i);
        exp_q[i][0].push_back(e);
      end
    @(negedge clk) conv_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midburst_reset");
    for (int i = 0; i < 2; i++) chk($sformatf("i%0d_prereset_words_seen", i),
                                    exp_q[i][0].size(), 0);
    last_fc = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_pair(1, 16'h0300, 2, 0, 16'h0000, 0);

    for (int n = 0; n < 40; n++) begin
      rc = 1'($urandom_range(0, 1));
      rf = 1'($urandom_range(0, 1));
      if (!rc && !rf) rc = 1'b1;
      run_pair(rc, 16'($urandom), $urandom_range(0, 7),
               rf, 16'($urandom), $urandom_range(0, 7));
    end

    for (int i = 0; i < 2; i++)
      for (int o = 0; o < 2; o++)
        chk($sformatf("i%0d_o%0d_words_outstanding", i, o), exp_q[i][o].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_sram_arbiter.md
# weight_sram_arbiter

Burst-read controller that shares one single-port weight SRAM between the convolution weight loader and the fully-connected weight fetcher. Each requester posts a base address and a burst length. The block grants one requester at a time and generates the sequential SRAM addresses. It routes the returned words back to the owner with valid and last flags. It sits between the SRAM macro and the two weight consumers, replacing the separate per-consumer address ports.

## Interface
- DW, 16, SRAM word width
- AW, 16, SRAM address width
- LW, 8, burst-length field width (length-minus-one encoding)
- RD_LAT, 1, SRAM read latency in cycles (1..4)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- conv_req  input  1  conv burst request, held until conv_ack
- conv_base  input  AW  conv burst start address
- conv_len  input  LW  conv burst length minus one
- conv_ack  output  1  one-cycle pulse: conv burst accepted
- conv_rdata  output  DW  returned word (equals sram_rdata)
- conv_rvalid  output  1  conv_rdata valid this cycle
- conv_rlast  output  1  final word of conv burst
- fc_req / fc_base / fc_len / fc_ack / fc_rdata / fc_rvalid / fc_rlast  same as conv_*, for the FC requester
- sram_ce  output  1  SRAM read enable
- sram_addr  output  AW  SRAM read address
- sram_rdata  input  DW  SRAM read data, valid RD_LAT cycles after sram_ce
- busy  output  1  high when state is not IDLE

## Operation
- FSM states:
  - IDLE: in IDLE with any req high, the arbiter picks the winner by policy, latches base/len/owner and moves to BURST.
  - BURST: issues one read per cycle, with sram_addr = base + cnt and cnt = 0..len. After issuing cnt == len, the FSM returns to IDLE.
- Default policy: fixed priority, with conv over fc.
- Address arithmetic is modulo 2^AW, so the address wraps from all-ones to zero.
- Burst length is len+1 words. len = 0 gives a single word, with rlast on that word.
- A requester must hold req, base and len stable until its ack. A req dropped before ack is ignored, and nothing is issued for it. base and len are sampled only in the grant cycle.
- Return tag pipeline:
  - RD_LAT stages, each carrying {valid, owner, last}, shifted every cycle.
  - The stage output drives the owner's rvalid and rlast.
  - The non-owner's rvalid is 0.
  - Both rdata ports carry sram_rdata unregistered.
- Reads already in the pipeline complete after the FSM re-enters IDLE or grants the other requester. There is no interleaving inside a burst.
- Consumers cannot stall. Every rvalid must be accepted.

## Timing
- Reset values: conv_ack, fc_ack, conv_rvalid, fc_rvalid, conv_rlast, fc_rlast, sram_ce and busy are 0. sram_addr is 0. The FSM is in IDLE, cnt is 0 and the pipeline is empty. Under RR, the pointer favours conv.
- Reset asserted mid-burst aborts immediately and clears all state. In-flight words produce no rvalid.
- The request is sampled in IDLE at cycle t. At t+1: ack = 1, sram_ce = 1, sram_addr = base, busy = 1.
- Word k is issued at t+1+k and returned (rvalid) at t+1+k+RD_LAT. rlast coincides with word len.
- IDLE is re-entered at t+2+len. The next grant's ack comes at t+3+len at the earliest, so there is one bubble between bursts.
- sram_ce, sram_addr, ack, rvalid, rlast and busy are all registered.
- When both reqs are sampled in the same IDLE cycle, exactly one ack fires. The loser keeps req high and wins the next IDLE.

## Configuration
- WSRAM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - A 1-bit pointer records the last-granted owner.
  - On a simultaneous request, the other owner wins. A single requester always wins.
- Undefined: fixed priority, conv over fc, and no pointer register.

## Structure
- Shared package (nice_pkg): FSM state enum (IDLE, BURST), owner encoding (OWN_CONV = 0, OWN_FC = 1), and the tag struct {valid, owner, last}.
- One sub-module: wsram_rd_tag_pipe, the parameterised RD_LAT-deep tag shift register with asynchronous reset.
- Top level: FSM, counter, arbitration and output decode.

## Test plan
- Single conv burst, base 0x0010, len 3, RD_LAT 1:
  - sram_addr 0x0010..0x0013 on 4 consecutive cycles.
  - conv_rvalid for 4 cycles, starting 1 cycle after the first sram_ce.
  - conv_rlast on the 4th word; fc_rvalid stays 0.
- conv and fc requested in the same cycle (fc base 0x0100, len 1), fixed priority:
  - conv burst completes first.
  - One bubble follows, then fc_ack, then reads of 0x0100 and 0x0101.
- Same stimulus repeated 3 times with WSRAM_ARB_RR_EN: grants alternate conv, fc, conv, fc, conv, fc.
- base 0xFFFE, len 2: addresses 0xFFFE, 0xFFFF, 0x0000; rlast on the 0x0000 word.
- len 0, RD_LAT 3: one sram_ce; a single rvalid with rlast 3 cycles later; busy for exactly 1 cycle.
- rst_n pulsed low during word 2 of a len-7 burst:
  - All outputs return to reset values immediately.
  - No further rvalid.
  - A fresh request after reset is accepted normally.
